latch_arbiter: RTL
==================

# latch_arbiter

Round-robin arbiter sharing a single `d_latch` storage element among four requesters. Grants exclusive write ownership to one requester at a time and drives the latch's enable and data inputs. After the owner releases, the latch is closed with data held stable for one cycle before ownership moves on. Sits between the requesting blocks and the shared `d_latch` instance; `latch_en` connects to the latch `clk`, and `latch_d` connects to the latch `D`.

## Interface
- `DW`, 8: data width of each requester bus and of `latch_d`.
- `HOLD_MAX`, 15: maximum grant length in cycles (used only with `LATCH_ARB_TIMEOUT_EN`); must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request per requester; level, held until released.
- `done`  in  4  release pulse per requester; honoured only for the current owner.
- `din`  in  4*DW  requester data, flattened; requester k occupies bits `[k*DW +: DW]`.
- `gnt`  out  4  one-hot grant; all-zero when idle.
- `owner`  out  2  index of the current or most recent owner.
- `busy`  out  1  high while any `gnt` bit is high.
- `latch_en`  out  1  latch transparent-enable.
- `latch_d`  out  DW  latch data.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: owner writes the latch.
  - RELEASE: latch closed, data held.
- IDLE:
  - If any `req` bit is set, pick the winner round-robin and go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - ptr = (last owner + 1) mod 4.
  - ptr = 0 after reset.
- GRANT:
  - `gnt[owner]` = 1, `latch_en` = 1.
  - Each edge that stays in GRANT loads `latch_d <= din[owner]`.
- Release condition: `done[owner]` = 1 or `req[owner]` = 0 → go to RELEASE.
  - On the exit edge, `latch_d` is NOT reloaded.
  - `gnt` and `latch_en` drop to 0 on that edge.
- RELEASE (exactly one cycle):
  - `latch_en` = 0 and `latch_d` holds its value; this gives the latch hold time.
  - Then go to GRANT with the next round-robin winner if any `req` is set, otherwise go to IDLE.
- Requester obligation: hold `din` stable from `gnt` rise until `done`. The stored value is `din[owner]` as sampled at the last edge before the exit edge.
- `done` or `din` from non-owners is ignored. Multiple simultaneous `req` bits are resolved by round-robin only.
- `latch_d` retains the last written value through IDLE.
- Reset values:
  - state IDLE; `gnt` 0; `owner` 0; `busy` 0; `latch_en` 0; `latch_d` 0; `timeout` 0.
  - ptr 0; hold counter 0.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. A grant in progress is abandoned and the latch keeps whatever it last captured.

## Timing
- All outputs are registered; none are combinational from the inputs.
- `req` rises before edge N while in IDLE → `gnt`, `latch_en` and `busy` are high after edge N.
  - `latch_d` shows `din[owner]` after edge N+1.
- `done` is high at edge M → `gnt` and `latch_en` are low after edge M.
  - RELEASE spans M to M+1.
  - The next owner's `gnt` is high after edge M+1.
- Minimum grant length is 2 cycles when `done` is delayed by one cycle. `done` sampled on the first GRANT edge is legal: the latch then holds the value loaded from the previous owner or reset.
- Back-to-back handover: exactly one cycle with `gnt` = 0 between owners.

## Configuration
- `LATCH_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to GRANT and increments on each GRANT cycle.
  - When `gnt` has been high for `HOLD_MAX` cycles without release, the FSM forces a move to RELEASE.
  - `timeout` pulses high for the RELEASE cycle.
  - ptr advances past the forced owner.
  - If `done` and the forced release coincide, the release is treated as normal and `timeout` stays 0.
- Not defined: no counter is present, grants are unbounded, and `timeout` is tied to 0.

## Test plan
- Reset, then `req`=0001 with `din0`=8'hA5 and `done0` pulsed 3 cycles after `gnt` → expect:
  - `gnt`=0001 one edge after `req`;
  - `latch_d`=A5 one edge later;
  - `gnt` and `latch_en` drop on the `done` edge;
  - `latch_d` stays A5 through RELEASE and IDLE.
- `req`=1111 held, each owner pulses `done` 2 cycles after its grant → grant order 0,1,2,3,0, with exactly one `gnt`=0 cycle between owners.
- Owner 1 drops `req1` with no `done`; `done3` pulsed by a non-owner → release occurs on the `req1` drop only, and `done3` has no effect.
- Macro defined, `HOLD_MAX`=15, `req2` held with no `done`, `req3` pending → `gnt[2]` high for exactly 15 cycles, then `timeout` pulses 1 cycle, then `gnt[3]` is granted. Macro undefined, same stimulus for 40 cycles → `gnt[2]` is held all 40 cycles and `timeout` stays 0.
- `rst` asserted between edges mid-grant with `latch_d`=8'h3C → `gnt`, `latch_en` and `latch_d` read 0 before the next edge. After deassert with `req`=1010, requester 1 wins first.
- `din0` changed while requester 2 owns → `latch_d` tracks only `din2`.

Source files
------------

// File: rtl/latch_arbiter.sv
// Round-robin arbiter granting four requesters exclusive write access to one shared d_latch.
// Optional forced release after HOLD_MAX grant cycles is enabled by defining LATCH_ARB_TIMEOUT_EN.
module latch_arbiter #(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [3:0]      done,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            latch_en,
    output logic [DW-1:0]   latch_d,
    output logic            timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("latch_arbiter: HOLD_MAX must be at least 2");
    end

    state_t        state;
    logic [1:0]    ptr;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic          release_req;
    logic          forced;
    logic [DW-1:0] din_arr [4];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        // Scan from the farthest offset down so the nearest requester to ptr is the final winner.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            din_arr[k] = din[k*DW +: DW];
        end
    end

    assign release_req = done[owner] | ~req[owner];

`ifdef LATCH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_cnt;

    // The counter reads k-1 on the k-th GRANT edge, so the grant lasts exactly HOLD_MAX cycles.
    assign forced = (state == GRANT) && (hold_cnt == CW'(HOLD_MAX - 1));
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= 4'b0000;
            owner    <= 2'd0;
            busy     <= 1'b0;
            latch_en <= 1'b0;
            latch_d  <= '0;
`ifdef LATCH_ARB_TIMEOUT_EN
            timeout  <= 1'b0;
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE, RELEASE: begin
`ifdef LATCH_ARB_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                    if (win_found) begin
                        state    <= GRANT;
                        owner    <= win_idx;
                        gnt      <= 4'b0001 << win_idx;
                        busy     <= 1'b1;
                        latch_en <= 1'b1;
                        ptr      <= win_idx + 2'd1;
`ifdef LATCH_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_req || forced) begin
                        // The exit edge closes the latch without reloading, keeping data stable for hold time.
                        state    <= RELEASE;
                        gnt      <= 4'b0000;
                        busy     <= 1'b0;
                        latch_en <= 1'b0;
`ifdef LATCH_ARB_TIMEOUT_EN
                        timeout  <= forced && !release_req;
`endif
                    end else begin
                        latch_d  <= din_arr[owner];
`ifdef LATCH_ARB_TIMEOUT_EN
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= 4'b0000;
                    busy     <= 1'b0;
                    latch_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
